// File: rtl/pipe_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM hazard inputs and stage-register controls.
// Purely a signal container; no logic, no added latency.
// No backpressure of its own; stalls are carried as enable/flush levels.
interface pipe_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        dm_ready;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_bubble;
  logic        mem_err;
  logic [15:0] stall_cnt;

  // Pipeline datapath side: supplies hazard inputs, consumes the controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_rd,
           ex_branch_taken, mem_req, dm_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, stall_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_rd,
           ex_branch_taken, mem_req, dm_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline hazard controller: memory-wait freeze, branch flush, load-use bubble, timeout.
// Enables/flushes are combinational (same cycle); mem_err/stall_cnt update on the next edge.
// A data-memory not-ready freezes upstream stages; 17 consecutive not-ready cycles latch ERR until reset.
module pipe_ctrl (
  input  logic         clk,
  input  logic         reset,
  pipe_ctrl_if.slave   pif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q;

  logic mem_stall;
  logic load_use;
  logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_ex_flush_c, mem_wb_bubble_c;

  // Hazard detection: memory not-ready only counts while the controller is live.
  always_comb begin
    mem_stall = (state != ST_ERR) && pif.mem_req && !pif.dm_ready;
    load_use  = pif.ex_is_load && (pif.ex_rd != 5'd0) &&
                ((pif.id_uses_rs && (pif.id_rs == pif.ex_rd)) ||
                 (pif.id_uses_rt && (pif.id_rt == pif.ex_rd)));
  end

  // Stage controls, in priority: reset, ERR, memory wait, taken branch, load-use, normal flow.
  always_comb begin
    pc_en_c         = 1'b1;
    if_id_en_c      = 1'b1;
    id_ex_en_c      = 1'b1;
    ex_mem_en_c     = 1'b1;
    mem_wb_en_c     = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    mem_wb_bubble_c = 1'b0;
    if (reset) begin
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      id_ex_en_c      = 1'b0;
      ex_mem_en_c     = 1'b0;
      mem_wb_en_c     = 1'b0;
      if_id_flush_c   = 1'b1;
      id_ex_flush_c   = 1'b1;
      mem_wb_bubble_c = 1'b1;
    end else if (state == ST_ERR) begin
      pc_en_c     = 1'b0;
      if_id_en_c  = 1'b0;
      id_ex_en_c  = 1'b0;
      ex_mem_en_c = 1'b0;
      mem_wb_en_c = 1'b0;
    end else if (mem_stall) begin
      // Freeze everything upstream of MEM; WB still advances but takes a bubble.
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      id_ex_en_c      = 1'b0;
      ex_mem_en_c     = 1'b0;
      mem_wb_bubble_c = 1'b1;
    end else if (pif.ex_branch_taken) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed; load-use is moot.
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID for one cycle, inject a bubble into EX.
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      id_ex_flush_c = 1'b1;
    end
  end

  // FSM plus sticky error flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= 4'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= 4'd0;
          if (mem_stall) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!mem_stall) begin
            state    <= ST_RUN;
            wait_cnt <= 4'd0;
          end else if (wait_cnt == 4'd15) begin
            state     <= ST_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          state     <= ST_ERR;
          mem_err_q <= 1'b1;
        end
      endcase
      if ((state != ST_ERR) && !pc_en_c && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Drive the interface.
  always_comb begin
    pif.pc_en         = pc_en_c;
    pif.if_id_en      = if_id_en_c;
    pif.id_ex_en      = id_ex_en_c;
    pif.ex_mem_en     = ex_mem_en_c;
    pif.mem_wb_en     = mem_wb_en_c;
    pif.if_id_flush   = if_id_flush_c;
    pif.id_ex_flush   = id_ex_flush_c;
    pif.mem_wb_bubble = mem_wb_bubble_c;
    pif.mem_err       = mem_err_q;
    pif.stall_cnt     = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl with a queue-based scoreboard.
// Driver pushes expected outputs each cycle; monitor pops and compares at the falling edge.
// Reference model counts consecutive memory stalls and total stall cycles directly.
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  pipe_ctrl_if pif();

  pipe_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       ld;
    logic [4:0] rd;
    logic       br;
    logic       mreq;
    logic       rdy;
  } stim_t;

  // ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  typedef struct {
    logic [7:0]  ctl;
    logic        known;
    logic        err;
    logic [15:0] scnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // Reference model state.
  int consec = 0;
  bit m_err = 1'b0;
  int m_scnt = 0;
  bit m_known = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rs = 5'd0; s.rt = 5'd0; s.urs = 1'b0; s.urt = 1'b0;
    s.ld = 1'b0; s.rd = 5'd0; s.br = 1'b0; s.mreq = 1'b0; s.rdy = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit lu, ms;
    @(posedge clk);
    #1;
    reset               = s.rst;
    pif.id_rs           = s.rs;
    pif.id_rt           = s.rt;
    pif.id_uses_rs      = s.urs;
    pif.id_uses_rt      = s.urt;
    pif.ex_is_load      = s.ld;
    pif.ex_rd           = s.rd;
    pif.ex_branch_taken = s.br;
    pif.mem_req         = s.mreq;
    pif.dm_ready        = s.rdy;
    lu = s.ld && (s.rd != 5'd0) && ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
    ms = !m_err && s.mreq && !s.rdy;
    if (s.rst)       e.ctl = 8'b00000_111;
    else if (m_err)  e.ctl = 8'b00000_000;
    else if (ms)     e.ctl = 8'b00001_001;
    else if (s.br)   e.ctl = 8'b11111_110;
    else if (lu)     e.ctl = 8'b00111_010;
    else             e.ctl = 8'b11111_000;
    e.known = m_known;
    e.err   = m_err;
    e.scnt  = m_scnt[15:0];
    q.push_back(e);
    // Advance the model to the state after this clock edge.
    if (s.rst) begin
      consec = 0; m_err = 1'b0; m_scnt = 0; m_known = 1'b1;
    end else if (!m_err) begin
      if (!e.ctl[7] && m_scnt < 65535) m_scnt++;
      if (ms) begin
        consec++;
        if (consec == 17) m_err = 1'b1;
      end else begin
        consec = 0;
      end
    end
  endtask

  task automatic driver();
    stim_t s;
    for (int i = 0; i < 2; i++) begin s = idle(); s.rst = 1'b1; step(s); end
    // Load-use on rs, then the same with ex_rd = 0 (no hazard).
    s = idle(); s.ld = 1'b1; s.rd = 5'd8; s.rs = 5'd8; s.urs = 1'b1; step(s);
    step(idle());
    s.rd = 5'd0; s.rs = 5'd0; step(s);
    // Load-use on rt, and rt match without use flag.
    s = idle(); s.ld = 1'b1; s.rd = 5'd3; s.rt = 5'd3; s.urt = 1'b1; step(s);
    s.urt = 1'b0; step(s);
    // Branch together with load-use.
    s = idle(); s.ld = 1'b1; s.rd = 5'd8; s.rs = 5'd8; s.urs = 1'b1; s.br = 1'b1; step(s);
    // Three not-ready cycles, then ready.
    s = idle(); s.mreq = 1'b1; s.rdy = 1'b0;
    for (int i = 0; i < 3; i++) step(s);
    s.rdy = 1'b1; step(s);
    // Zero-wait access, with a branch on top.
    s = idle(); s.mreq = 1'b1; s.rdy = 1'b1; step(s);
    s.br = 1'b1; step(s);
    // Stall plus branch: stall wins.
    s = idle(); s.mreq = 1'b1; s.rdy = 1'b0; s.br = 1'b1; step(s);
    step(idle());
    // Timeout into ERR, linger, then reset out of it.
    s = idle(); s.mreq = 1'b1; s.rdy = 1'b0;
    for (int i = 0; i < 20; i++) step(s);
    s = idle(); s.br = 1'b1; step(s);
    s = idle(); s.ld = 1'b1; s.rd = 5'd1; s.rs = 5'd1; s.urs = 1'b1; step(s);
    s = idle(); s.rst = 1'b1; step(s);
    step(idle());
    // 16 not-ready cycles then ready: just under the timeout.
    s = idle(); s.mreq = 1'b1; s.rdy = 1'b0;
    for (int i = 0; i < 16; i++) step(s);
    s.rdy = 1'b1; step(s);
    // Random traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 4000; i++) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.ld   = 1'($urandom_range(0, 1));
      s.rd   = 5'($urandom_range(0, 3));
      s.br   = ($urandom_range(0, 4) == 0);
      s.mreq = 1'($urandom_range(0, 1));
      s.rdy  = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      step(s);
    end
    // Saturation: continuous load-use from a fresh reset, past 0xFFFF.
    s = idle(); s.rst = 1'b1; step(s);
    s = idle(); s.ld = 1'b1; s.rd = 5'd5; s.rt = 5'd5; s.urt = 1'b1;
    for (int i = 0; i < 65534 + 3; i++) step(s);
    s.br = 1'b1; step(s);
    step(idle());
    step(idle());
    done = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    logic [7:0] got;
    while (!done || q.size() != 0) begin
      @(negedge clk);
      if (q.size() == 0) continue;
      e = q.pop_front();
      got = {pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_mem_en, pif.mem_wb_en,
             pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_bubble};
      checks++;
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL ctl @%0t got %b want %b", $time, got, e.ctl);
      end
      if (e.known) begin
        checks++;
        if (pif.mem_err !== e.err || pif.stall_cnt !== e.scnt) begin
          errors++;
          $display("FAIL regs @%0t got err=%b cnt=%h want err=%b cnt=%h",
                   $time, pif.mem_err, pif.stall_cnt, e.err, e.scnt);
        end
      end
    end
  endtask

  initial begin
    reset               = 1'b1;
    pif.id_rs           = 5'd0;
    pif.id_rt           = 5'd0;
    pif.id_uses_rs      = 1'b0;
    pif.id_uses_rt      = 1'b0;
    pif.ex_is_load      = 1'b0;
    pif.ex_rd           = 5'd0;
    pif.ex_branch_taken = 1'b0;
    pif.mem_req         = 1'b0;
    pif.dm_ready        = 1'b1;
    fork
      driver();
      monitor();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
